// File: rtl/his_builder_peak_multi.sv
// Per-pixel dToF histogram builder with a running peak search and per-frame peak readout.
// Optional HIS_OVERFLOW_FLAG_EN adds a peakOvf output reporting per-pixel bin saturation.
module his_builder_peak_multi #(
  parameter int DATA_W    = 10,
  parameter int BIN_W     = 6,
  parameter int CNT_W     = 8,
  parameter int PIXEL_NUM = 3,
  parameter int SAMP_NUM  = 2,
  parameter int ACQ_NUM   = 2,
  parameter int PIX_W     = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              peakValid,
  output logic [PIX_W-1:0]  peakPix,
  output logic [BIN_W-1:0]  peakBin,
  output logic [CNT_W-1:0]  peakCnt,
`ifdef HIS_OVERFLOW_FLAG_EN
  output logic              peakOvf,
`endif
  output logic              peakLast
);

  localparam int ADDR_W = PIX_W + BIN_W;
  localparam int DEPTH  = PIXEL_NUM << BIN_W;
  localparam int SAMP_W = (SAMP_NUM > 1) ? $clog2(SAMP_NUM) : 1;
  localparam int ACQ_W  = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(SAMP_NUM - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIXEL_NUM - 1);
  localparam logic [ACQ_W-1:0]  LAST_ACQ  = ACQ_W'(ACQ_NUM - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, READOUT} stateT;

  stateT             state;
  logic [CNT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] clrAddr;
  logic [SAMP_W-1:0] sampCnt;
  logic [PIX_W-1:0]  pixCnt;
  logic [ACQ_W-1:0]  acqCnt;
  logic              drainCnt;
  logic [PIX_W-1:0]  rdPix;
  logic [PIX_W-1:0]  nxtPix;
  logic              s1Valid;
  logic [ADDR_W-1:0] s1Addr;
  logic [PIX_W-1:0]  s1Pix;
  logic [BIN_W-1:0]  s1Bin;
  logic [CNT_W-1:0]  s1Old;
  logic [CNT_W-1:0]  s1New;
  logic [BIN_W-1:0]  sampBin;
  logic [ADDR_W-1:0] wrAddr;
  logic [CNT_W-1:0]  peakCntR [PIXEL_NUM];
  logic [BIN_W-1:0]  peakBinR [PIXEL_NUM];
`ifdef HIS_OVERFLOW_FLAG_EN
  logic              ovfR [PIXEL_NUM];
`endif
  logic              unusedLowBits;

  assign sampBin       = data[DATA_W-1 -: BIN_W];
  assign unusedLowBits = ^data[DATA_W-BIN_W-1:0];
  assign wrAddr        = {pixCnt, sampBin};
  assign nxtPix        = rdPix + 1'b1;
  assign s1New         = (s1Old == CNT_MAX) ? s1Old : s1Old + 1'b1;

  // Histogram RAM: clear sweep or S1 write-back; the read bypasses a same-address write in flight.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clrAddr] <= '0;
    else if (s1Valid)
      mem[s1Addr] <= s1New;
    s1Old <= (s1Valid && (s1Addr == wrAddr)) ? s1New : mem[wrAddr];
  end

  // Frame sequencing, S1 peak tracking and registered readout.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= CLEAR;
      clrAddr   <= '0;
      sampCnt   <= '0;
      pixCnt    <= '0;
      acqCnt    <= '0;
      drainCnt  <= 1'b0;
      rdPix     <= '0;
      s1Valid   <= 1'b0;
      s1Addr    <= '0;
      s1Pix     <= '0;
      s1Bin     <= '0;
      ready     <= 1'b0;
      peakValid <= 1'b0;
      peakPix   <= '0;
      peakBin   <= '0;
      peakCnt   <= '0;
      peakLast  <= 1'b0;
`ifdef HIS_OVERFLOW_FLAG_EN
      peakOvf   <= 1'b0;
`endif
      for (int i = 0; i < PIXEL_NUM; i++) begin
        peakCntR[i] <= '0;
        peakBinR[i] <= '0;
`ifdef HIS_OVERFLOW_FLAG_EN
        ovfR[i]     <= 1'b0;
`endif
      end
    end else begin
      s1Valid <= 1'b0;
      // Strict compare keeps the bin that reached a tied count first.
      if (s1Valid) begin
        if (s1New > peakCntR[s1Pix]) begin
          peakCntR[s1Pix] <= s1New;
          peakBinR[s1Pix] <= s1Bin;
        end
`ifdef HIS_OVERFLOW_FLAG_EN
        if (s1New == CNT_MAX) ovfR[s1Pix] <= 1'b1;
`endif
      end
      case (state)
        CLEAR: begin
          clrAddr <= clrAddr + 1'b1;
          for (int i = 0; i < PIXEL_NUM; i++) begin
            peakCntR[i] <= '0;
            peakBinR[i] <= '0;
`ifdef HIS_OVERFLOW_FLAG_EN
            ovfR[i]     <= 1'b0;
`endif
          end
          if (clrAddr == LAST_ADDR) begin
            clrAddr <= '0;
            state   <= ACCUM;
            ready   <= 1'b1;
          end
        end
        ACCUM: begin
          if (wrEn) begin
            s1Valid <= 1'b1;
            s1Addr  <= wrAddr;
            s1Pix   <= pixCnt;
            s1Bin   <= sampBin;
            if (sampCnt == LAST_SAMP) begin
              sampCnt <= '0;
              if (pixCnt == LAST_PIX) begin
                pixCnt <= '0;
                if (acqCnt == LAST_ACQ) begin
                  acqCnt   <= '0;
                  state    <= DRAIN;
                  ready    <= 1'b0;
                  drainCnt <= 1'b0;
                end else begin
                  acqCnt <= acqCnt + 1'b1;
                end
              end else begin
                pixCnt <= pixCnt + 1'b1;
              end
            end else begin
              sampCnt <= sampCnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          drainCnt <= 1'b1;
          if (drainCnt) begin
            state     <= READOUT;
            rdPix     <= '0;
            peakValid <= 1'b1;
            peakPix   <= '0;
            peakBin   <= peakBinR[0];
            peakCnt   <= peakCntR[0];
            peakLast  <= (PIXEL_NUM == 1);
`ifdef HIS_OVERFLOW_FLAG_EN
            peakOvf   <= ovfR[0];
`endif
          end
        end
        READOUT: begin
          if (rdPix == LAST_PIX) begin
            peakValid <= 1'b0;
            peakLast  <= 1'b0;
`ifdef HIS_OVERFLOW_FLAG_EN
            peakOvf   <= 1'b0;
`endif
            state     <= CLEAR;
          end else begin
            rdPix     <= nxtPix;
            peakPix   <= nxtPix;
            peakBin   <= peakBinR[nxtPix];
            peakCnt   <= peakCntR[nxtPix];
            peakLast  <= (nxtPix == LAST_PIX);
`ifdef HIS_OVERFLOW_FLAG_EN
            peakOvf   <= ovfR[nxtPix];
`endif
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_his_builder_peak_multi.sv
// Bench for his_builder_peak_multi: default-parameter frames checked against a histogram model,
// plus two small configurations (tie and saturation) checked against hand-computed values.
module tb_his_builder_peak_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic       wrEn, wrEn2, wrEn3;
  logic [9:0] data, data2, data3;
  logic       ready, ready2, ready3;
  logic       peakValid, peakValid2, peakValid3;
  logic [1:0] peakPix;
  logic [0:0] peakPix2, peakPix3;
  logic [5:0] peakBin, peakBin2, peakBin3;
  logic [7:0] peakCnt, peakCnt2;
  logic [1:0] peakCnt3;
  logic       peakLast, peakLast2, peakLast3;
`ifdef HIS_OVERFLOW_FLAG_EN
  logic       peakOvf, peakOvf2, peakOvf3;
`endif

  int errors = 0;
  int checks = 0;
  int rdCount = 0;
  int capPix [16];
  int capBin [16];
  int capCnt [16];
  int capLast [16];

  typedef struct {
    int pix;
    int bin;
    int cnt;
    bit last;
    bit ovf;
  } expT;
  expT expQ[$];
  expT e;

  logic [9:0] frameQ[$] = '{10'd108, 10'd511, 10'd1022, 10'd1023, 10'd200, 10'd90,
                            10'd300, 10'd500, 10'd50, 10'd1000, 10'd48, 10'd90};

  always #5 clock = ~clock;

  his_builder_peak_multi dut (
    .clk(clock), .res(reset), .wrEn(wrEn), .data(data), .ready(ready),
    .peakValid(peakValid), .peakPix(peakPix), .peakBin(peakBin), .peakCnt(peakCnt),
`ifdef HIS_OVERFLOW_FLAG_EN
    .peakOvf(peakOvf),
`endif
    .peakLast(peakLast)
  );

  his_builder_peak_multi #(.PIXEL_NUM(1), .ACQ_NUM(1)) dut2 (
    .clk(clock), .res(reset), .wrEn(wrEn2), .data(data2), .ready(ready2),
    .peakValid(peakValid2), .peakPix(peakPix2), .peakBin(peakBin2), .peakCnt(peakCnt2),
`ifdef HIS_OVERFLOW_FLAG_EN
    .peakOvf(peakOvf2),
`endif
    .peakLast(peakLast2)
  );

  his_builder_peak_multi #(.CNT_W(2), .SAMP_NUM(5), .ACQ_NUM(1), .PIXEL_NUM(1)) dut3 (
    .clk(clock), .res(reset), .wrEn(wrEn3), .data(data3), .ready(ready3),
    .peakValid(peakValid3), .peakPix(peakPix3), .peakBin(peakBin3), .peakCnt(peakCnt3),
`ifdef HIS_OVERFLOW_FLAG_EN
    .peakOvf(peakOvf3),
`endif
    .peakLast(peakLast3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: walk the pixel-sequential sample list, build the histograms and track
  // the first bin to reach each new highest count.
  task automatic modelFrame(input logic [9:0] s[$]);
    int hist [3][64];
    int pkCnt [3];
    int pkBin [3];
    bit ovf [3];
    expT r;
    for (int p = 0; p < 3; p++) begin
      pkCnt[p] = 0;
      pkBin[p] = 0;
      ovf[p] = 0;
      for (int b = 0; b < 64; b++) hist[p][b] = 0;
    end
    for (int i = 0; i < s.size(); i++) begin
      int p, b;
      p = (i / 2) % 3;
      b = int'(s[i]) / 16;
      if (hist[p][b] < 255) hist[p][b] = hist[p][b] + 1;
      if (hist[p][b] == 255) ovf[p] = 1;
      if (hist[p][b] > pkCnt[p]) begin
        pkCnt[p] = hist[p][b];
        pkBin[p] = b;
      end
    end
    for (int p = 0; p < 3; p++) begin
      r.pix = p;
      r.bin = pkBin[p];
      r.cnt = pkCnt[p];
      r.last = (p == 2);
      r.ovf = ovf[p];
      expQ.push_back(r);
    end
  endtask

  // Compare process for the default instance: every valid result must match the model in order.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (peakValid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected peakValid", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("peakPix", 32'(peakPix), e.pix);
          checkOutput("peakBin", 32'(peakBin), e.bin);
          checkOutput("peakCnt", 32'(peakCnt), e.cnt);
          checkOutput("peakLast", 32'(peakLast), 32'(e.last));
`ifdef HIS_OVERFLOW_FLAG_EN
          checkOutput("peakOvf", 32'(peakOvf), 32'(e.ovf));
`endif
        end
        if (rdCount < 16) begin
          capPix[rdCount]  = int'(peakPix);
          capBin[rdCount]  = int'(peakBin);
          capCnt[rdCount]  = int'(peakCnt);
          capLast[rdCount] = int'(peakLast);
        end
        rdCount++;
      end else if (peakLast === 1'b1) begin
        checkOutput("peakLast without peakValid", 1, 0);
      end
    end
  end

  task automatic drive(input int which, input logic en, input logic [9:0] d);
    case (which)
      2: begin wrEn2 = en; data2 = d; end
      3: begin wrEn3 = en; data3 = d; end
      default: begin wrEn = en; data = d; end
    endcase
  endtask

  // Retire the previously driven sample, idle for gap cycles, then present the next one once ready.
  task automatic applyStimulus(input int which, input logic [9:0] d, input int gap);
    int guard = 0;
    logic rdy;
    @(posedge clock); #1;
    drive(which, 1'b0, 10'd0);
    repeat (gap) begin @(posedge clock); #1; end
    rdy = (which == 2) ? ready2 : (which == 3) ? ready3 : ready;
    while (rdy !== 1'b1 && guard < 1000) begin
      @(posedge clock); #1;
      guard++;
      rdy = (which == 2) ? ready2 : (which == 3) ? ready3 : ready;
    end
    if (rdy !== 1'b1) checkOutput("ready timeout", 0, 1);
    drive(which, 1'b1, d);
  endtask

  task automatic finishSamples();
    @(posedge clock); #1;
    wrEn = 1'b0; wrEn2 = 1'b0; wrEn3 = 1'b0;
  endtask

  task automatic waitReadouts(input int target);
    int guard = 0;
    while (rdCount < target && guard < 2000) begin
      @(posedge clock); #1;
      guard++;
    end
    @(posedge clock); #1;
    checkOutput("readout count", rdCount, target);
  endtask

  task automatic checkFrameLiterals(input int base, input string tag);
    checkOutput({tag, " p0 bin"}, capBin[base], 31);
    checkOutput({tag, " p1 bin"}, capBin[base+1], 63);
    checkOutput({tag, " p1 cnt fwd"}, capCnt[base+1], 2);
    checkOutput({tag, " p2 bin"}, capBin[base+2], 5);
    checkOutput({tag, " p2 pix"}, capPix[base+2], 2);
    checkOutput({tag, " p2 last"}, capLast[base+2], 1);
    checkOutput({tag, " p0 last"}, capLast[base], 0);
  endtask

  task automatic waitSmallValid(input int which);
    int guard = 0;
    logic v;
    v = (which == 2) ? peakValid2 : peakValid3;
    while (v !== 1'b1 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
      v = (which == 2) ? peakValid2 : peakValid3;
    end
    if (v !== 1'b1) checkOutput("small peakValid timeout", 0, 1);
  endtask

  initial begin
    int zeroCycles;
    reset = 1'b1;
    wrEn = 1'b0; wrEn2 = 1'b0; wrEn3 = 1'b0;
    data = '0; data2 = '0; data3 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    checkOutput("reset ready", 32'(ready), 0);
    checkOutput("reset peakValid", 32'(peakValid), 0);
    checkOutput("reset peakPix", 32'(peakPix), 0);
    checkOutput("reset peakBin", 32'(peakBin), 0);
    checkOutput("reset peakCnt", 32'(peakCnt), 0);
    checkOutput("reset peakLast", 32'(peakLast), 0);

    // Samples offered during CLEAR must be dropped without effect.
    zeroCycles = 0;
    while (ready !== 1'b1 && zeroCycles < 400) begin
      zeroCycles++;
      if (zeroCycles == 10) begin wrEn = 1'b1; data = 10'd1000; end
      if (zeroCycles == 20) wrEn = 1'b0;
      @(posedge clock); #1;
    end
    checkOutput("clear cycles with ready=0", zeroCycles, 192);

    $display("[TB] frame 1, back-to-back samples");
    modelFrame(frameQ);
    foreach (frameQ[i]) applyStimulus(1, frameQ[i], 0);
    finishSamples();
    waitReadouts(3);
    checkFrameLiterals(0, "frame1");
    checkOutput("frame1 queue drained", expQ.size(), 0);

    $display("[TB] aborted frame then frame with gaps");
    applyStimulus(1, 10'd1000, 0);
    applyStimulus(1, 10'd1000, 0);
    applyStimulus(1, 10'd1010, 0);
    finishSamples();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("no partial readout", rdCount, 3);
    modelFrame(frameQ);
    foreach (frameQ[i]) applyStimulus(1, frameQ[i], $urandom_range(0, 3));
    finishSamples();
    waitReadouts(6);
    checkFrameLiterals(3, "frame2");

    $display("[TB] single pixel tie");
    applyStimulus(2, 10'd200, 0);
    applyStimulus(2, 10'd90, 0);
    finishSamples();
    waitSmallValid(2);
    checkOutput("tie peakBin", 32'(peakBin2), 12);
    checkOutput("tie peakCnt", 32'(peakCnt2), 1);
    checkOutput("tie peakPix", 32'(peakPix2), 0);
    checkOutput("tie peakLast", 32'(peakLast2), 1);
`ifdef HIS_OVERFLOW_FLAG_EN
    checkOutput("tie peakOvf", 32'(peakOvf2), 0);
`endif
    @(posedge clock); #1;
    checkOutput("tie peakValid ends", 32'(peakValid2), 0);

    $display("[TB] saturating counter");
    for (int i = 0; i < 5; i++) applyStimulus(3, 10'd1000, 0);
    finishSamples();
    waitSmallValid(3);
    checkOutput("sat peakBin", 32'(peakBin3), 62);
    checkOutput("sat peakCnt", 32'(peakCnt3), 3);
    checkOutput("sat peakLast", 32'(peakLast3), 1);
    checkOutput("sat peakPix", 32'(peakPix3), 0);
`ifdef HIS_OVERFLOW_FLAG_EN
    checkOutput("sat peakOvf", 32'(peakOvf3), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
